cache_line_memory: RTL
======================

CACHE_LINE_MEMORY -- requirements
Module: cache_line_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to mem_ready; legal range 1..15.
REQ-002 SHALL have parameter MEM_LINES, default 1024, meaning number of 128-bit lines stored; power of two, 2..65536.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port mem_req_valid, input, 1, request strobe from cache controller.
REQ-006 SHALL have port mem_req_rw, input, 1, 1 = line write, 0 = line read.
REQ-007 SHALL have port mem_req_addr, input, 32, byte address; bits [3:0] ignored.
REQ-008 SHALL have port mem_req_data, input, 128, write line data.
REQ-009 SHALL have port mem_ready, output, 1, one-cycle response strobe to cache controller.
REQ-010 SHALL have port mem_rdata, output, 128, read line data, valid only while mem_ready=1.
REQ-011 SHALL have port busy, output, 1, high while a request is outstanding (WAIT or RESP).
REQ-012 SHALL have port req_dropped, output, 1, sticky flag: a request was ignored.

Function
REQ-013 SHALL implement states IDLE, WAIT, RESP.
REQ-014 SHALL accept a request when mem_req_valid=1 and state is IDLE or RESP; acceptance latches rw, addr[31:4], and data into internal registers.
REQ-015 SHALL treat mem_req_valid as a single-cycle strobe; a held-high valid is a new request in each accepting cycle.
REQ-016 SHALL assert mem_ready exactly LATENCY cycles after the acceptance cycle, for exactly one cycle (state RESP).
REQ-017 SHALL, with LATENCY=1, go from acceptance directly to RESP; with LATENCY>1, go through WAIT for LATENCY-1 cycles, using a 4-bit down-counter.
REQ-018 SHALL select the line by index = latched addr[4 +: log2(MEM_LINES)]; higher address bits are ignored (aliasing).
REQ-019 SHALL, for a read, drive mem_rdata in RESP with the stored line content as it is at the start of the RESP cycle.
REQ-020 SHALL, for a write, commit the latched data to the indexed line at the clock edge ending RESP; mem_rdata = 0 during write response.
REQ-021 SHALL drive mem_rdata = 0 whenever mem_ready=0.
REQ-022 SHALL accept a new request in the RESP cycle (back-to-back): next state WAIT, or RESP if LATENCY=1; a write committed in that RESP is visible to the new read.
REQ-023 SHALL return from RESP to IDLE when no request is present in the RESP cycle.
REQ-024 SHALL ignore mem_req_valid in WAIT: no state change, latched request unchanged, req_dropped set to 1.
REQ-025 SHALL keep req_dropped at 1 until rst.
REQ-026 SHALL drive busy = 1 in WAIT and RESP, 0 in IDLE.
REQ-027 SHALL initialise storage to all zeros at time zero; storage has no reset.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set the state to IDLE, the counter to 0, and req_dropped to 0, and drop any in-flight request; a pending write is not committed.
REQ-029 SHALL drive mem_ready=0, mem_rdata=0, busy=0, and req_dropped=0 in the cycle after reset.
REQ-030 SHALL preserve storage contents across rst.
REQ-031 SHALL ignore mem_req_valid in any cycle in which rst=1.

Verification
REQ-032 Bench SHALL cover: LATENCY=4, write addr 0x0000_0010 data 0x11112222_33334444_55556666_77778888 at cycle T -> mem_ready=1 at exactly T+4 only, busy=1 for T+1..T+4.
REQ-033 Bench SHALL cover: read 0x0000_0010 after REQ-032 -> mem_ready 4 cycles later with mem_rdata = written line; read 0x0000_0020 -> all zeros.
REQ-034 Bench SHALL cover: write 0x40 with data A, plus read 0x40 issued in the write's RESP cycle (write-back then allocate) -> second mem_ready exactly 4 cycles after first, mem_rdata=A.
REQ-035 Bench SHALL cover: request issued 2 cycles into WAIT -> ignored, req_dropped=1 and stays 1, only one mem_ready seen.
REQ-036 Bench SHALL cover: rst asserted in WAIT of a write to 0x80 -> mem_ready never asserted, busy=0, later read 0x80 returns old content.
REQ-037 Bench SHALL cover: LATENCY=1, back-to-back reads on consecutive cycles -> mem_ready high on consecutive cycles with correct data each cycle; MEM_LINES=1024 aliasing: write 0x4010 equals line of 0x0010.

Source files
------------

// File: rtl/cache_line_memory.sv
// Fixed-latency 128-bit line memory behind a cache controller.
// A request is accepted in IDLE or RESP and answered with a one-cycle mem_ready strobe LATENCY cycles later.
module cache_line_memory #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_LINES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_req_valid,
    input  logic         mem_req_rw,
    input  logic [31:0]  mem_req_addr,
    input  logic [127:0] mem_req_data,
    output logic         mem_ready,
    output logic [127:0] mem_rdata,
    output logic         busy,
    output logic         req_dropped
);

    localparam int unsigned IDX_W    = $clog2(MEM_LINES);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             dropped_q, dropped_d;
    logic             rw_q, rw_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     data_q, data_d;
    logic             accept;

    // Storage has no reset; contents survive rst.
    logic [127:0] mem_q [MEM_LINES] = '{default: '0};

    // Only the line index bits of the address select storage; the rest alias.
    logic unused_addr;
    assign unused_addr = ^{mem_req_addr[3:0], mem_req_addr[31:4+IDX_W]};

    assign accept = mem_req_valid && ((state_q == S_IDLE) || (state_q == S_RESP));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        rw_d      = rw_q;
        idx_d     = idx_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                if (mem_req_valid) begin
                    dropped_d = 1'b1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Acceptance in RESP overrides the return to IDLE (back-to-back).
        if (accept) begin
            rw_d   = mem_req_rw;
            idx_d  = mem_req_addr[4 +: IDX_W];
            data_d = mem_req_data;
            if (LATENCY == 1) begin
                state_d = S_RESP;
                cnt_d   = '0;
            end else begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rw_q   <= rw_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    // A write commits at the edge that ends its RESP cycle, unless reset lands there.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_RESP) && rw_q) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign mem_ready   = (state_q == S_RESP);
    assign mem_rdata   = (mem_ready && !rw_q) ? mem_q[idx_q] : '0;
    assign busy        = (state_q == S_WAIT) || (state_q == S_RESP);
    assign req_dropped = dropped_q;

endmodule
